// File: rtl/ofm_read_data_pkg.sv
// Shared state encoding and helpers for the psum read-side drain.
// Imported by the controller and its read-port/stream interface users.
package ofm_read_data_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam int unsigned OFM_SIZE_DEF = 7;

  function automatic int unsigned n_pix(
    input int unsigned ofm_size
  );
    return ofm_size * ofm_size;
  endfunction

  // High when ReLU must force the word to zero
  function automatic logic relu_zero(
    input logic en,
    input logic sign
  );
    return en & sign;
  endfunction

endpackage

// File: rtl/ofm_read_data_if.sv
// Psum buffer read port plus the output word stream.
// master = drain controller, slave = buffer/packer side.
interface ofm_read_data_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 6
);

  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;

  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;

  modport master (
    output rd_en,
    output rd_addr,
    input  rd_data,
    output out_data,
    output out_valid,
    input  out_ready,
    output out_last
  );

  modport slave (
    input  rd_en,
    input  rd_addr,
    output rd_data,
    input  out_data,
    input  out_valid,
    output out_ready,
    input  out_last
  );

endinterface

// File: rtl/ofm_read_data_psum_skid_fifo.sv
// Two-entry register FIFO between psum read data and the stream.
// Head word is registered so out_data is stable while stalled.
module psum_skid_fifo #(
  parameter int WIDTH = 16
) (
  input  logic             clk2,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] s0_q, s0_d;
  logic [WIDTH-1:0] s1_q, s1_d;
  logic [1:0]       cnt_q, cnt_d;

  always_comb begin
    s0_d  = s0_q;
    s1_d  = s1_q;
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10: begin
        if (cnt_q == 2'd0) begin
          s0_d = din;
        end else begin
          s1_d = din;
        end
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        // Head keeps its value when emptying
        if (cnt_q == 2'd2) begin
          s0_d = s1_q;
        end
        cnt_d = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd2) begin
          s0_d = s1_q;
          s1_d = din;
        end else begin
          s0_d = din;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk2) begin
    if (rst) begin
      s0_q  <= '0;
      s1_q  <= '0;
      cnt_q <= 2'd0;
    end else begin
      s0_q  <= s0_d;
      s1_q  <= s1_d;
      cnt_q <= cnt_d;
    end
  end

  assign dout  = s0_q;
  assign valid = (cnt_q != 2'd0);
  assign count = cnt_q;

endmodule

// File: rtl/ofm_read_data.sv
// Drains a finished OFM from the psum buffer in raster order,
// applies optional ReLU and streams words over valid/ready.
module ofm_read_data
  import ofm_read_data_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned OFM_SIZE   = OFM_SIZE_DEF,
  parameter int unsigned ADDR_WIDTH = 6
) (
  input  logic clk2,
  input  logic rst,
  input  logic start_read,
  input  logic relu_en,
  output logic busy,
  output logic done,
  ofm_read_data_if.master bus
);

  localparam int unsigned N_PIX = n_pix(OFM_SIZE);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX =
    ADDR_WIDTH'(N_PIX - 1);

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] ocnt_q, ocnt_d;
  logic                  relu_q, relu_d;
  logic                  inflight_q, inflight_d;

  logic [DATA_WIDTH-1:0] fifo_dout;
  logic [DATA_WIDTH-1:0] push_data;
  logic                  fifo_valid;
  logic [1:0]            fifo_cnt;
  logic                  pop;
  logic                  issue;
  logic [2:0]            occ;

  assign pop = fifo_valid & bus.out_ready;

  // Occupancy after this cycle's pop, counting the read in flight
  assign occ = 3'(fifo_cnt) + 3'(inflight_q) - 3'(pop);

  assign issue = (state_q == ST_READ) && (occ < 3'd2);

  assign push_data =
    relu_zero(relu_q, bus.rd_data[DATA_WIDTH-1]) ?
    '0 : bus.rd_data;

  psum_skid_fifo #(
    .WIDTH(DATA_WIDTH)
  ) u_fifo (
    .clk2  (clk2),
    .rst   (rst),
    .push  (inflight_q),
    .din   (push_data),
    .pop   (pop),
    .dout  (fifo_dout),
    .valid (fifo_valid),
    .count (fifo_cnt)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    ocnt_d     = ocnt_q;
    relu_d     = relu_q;
    inflight_d = issue;
    if (pop) begin
      ocnt_d = ocnt_q + ADDR_WIDTH'(1);
    end
    case (state_q)
      ST_IDLE: begin
        if (start_read) begin
          state_d = ST_READ;
          relu_d  = relu_en;
          addr_d  = '0;
          ocnt_d  = '0;
        end
      end
      ST_READ: begin
        if (issue) begin
          if (addr_q == LAST_IDX) begin
            state_d = ST_DRAIN;
          end else begin
            addr_d = addr_q + ADDR_WIDTH'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (pop && bus.out_last) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk2) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      ocnt_q     <= '0;
      relu_q     <= 1'b0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      ocnt_q     <= ocnt_d;
      relu_q     <= relu_d;
      inflight_q <= inflight_d;
    end
  end

  assign bus.rd_en     = issue;
  assign bus.rd_addr   = addr_q;
  assign bus.out_data  = fifo_dout;
  assign bus.out_valid = fifo_valid;
  assign bus.out_last  = fifo_valid && (ocnt_q == LAST_IDX);

  assign busy = (state_q == ST_READ) || (state_q == ST_DRAIN);
  assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_ofm_read_data.sv
// Bench for ofm_read_data: cycle table, reference stream model,
// random backpressure, stall, mid-drain start and reset cases.
module tb_ofm_read_data;

  localparam int N = 49;

  logic clk2 = 1'b0;
  logic rst;
  logic start_read;
  logic relu_en;
  logic busy;
  logic done;

  ofm_read_data_if #(.DATA_WIDTH(16), .ADDR_WIDTH(6)) bus();

  ofm_read_data #(
    .DATA_WIDTH(16),
    .OFM_SIZE  (7),
    .ADDR_WIDTH(6)
  ) dut (
    .clk2      (clk2),
    .rst       (rst),
    .start_read(start_read),
    .relu_en   (relu_en),
    .busy      (busy),
    .done      (done),
    .bus       (bus)
  );

  initial forever #5 clk2 = ~clk2;

  logic [15:0] mem [64];

  // Buffer returns data one cycle after the strobe, junk otherwise
  always @(posedge clk2) begin
    if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
    else           bus.rd_data <= 16'($urandom);
  end

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(
    input string name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endfunction

  typedef struct packed {
    logic        start;
    logic        ready;
    logic        rd_en;
    logic [5:0]  addr;
    logic        valid;
    logic [15:0] data;
    logic        busy;
  } vec_t;

  vec_t tbl [9];

  logic [15:0] got [$];
  int first_cyc, last_cyc, done_cyc, done_cnt;

  task automatic fill_ramp();
    for (int k = 0; k < 64; k++) mem[k] = 16'(k);
  endtask

  task automatic fill_alt();
    for (int k = 0; k < 64; k++)
      mem[k] = (k % 2 == 0) ? 16'hFFFB : 16'd7;
  endtask

  task automatic check_stream(input string nm, input bit relu);
    logic [15:0] e;
    int lim;
    chk({nm, "_count"}, got.size(), N);
    lim = (got.size() < N) ? got.size() : N;
    for (int k = 0; k < lim; k++) begin
      e = mem[k];
      if (relu && $signed(e) < 0) e = 16'd0;
      chk({nm, "_word"}, got[k], e);
    end
    chk({nm, "_done_cnt"}, done_cnt, 1);
  endtask

  // mode 0: ready=1, 1: random, 2: 20-cycle stall after first valid
  task automatic drain(input int mode, input bit relu, input bit mid);
    int issued, popped;
    bit pv, pr, pl, seen;
    logic [15:0] pd;
    got.delete();
    first_cyc = -1; last_cyc = -1; done_cyc = -1; done_cnt = 0;
    issued = 0; popped = 0;
    pv = 0; pr = 0; pl = 0; pd = '0; seen = 0;
    start_read = 1'b1;
    relu_en = relu;
    bus.out_ready = 1'b1;
    @(posedge clk2); #1;
    start_read = 1'b0;
    for (int c = 1; c < 1000 && !seen; c++) begin
      relu_en = ~relu;
      start_read = mid && (c == 20);
      case (mode)
        1: bus.out_ready = 1'($urandom_range(0, 1));
        2: bus.out_ready = !(c >= 3 && c < 23);
        default: bus.out_ready = 1'b1;
      endcase
      @(negedge clk2);
      if (bus.rd_en) begin
        chk("rd_addr", bus.rd_addr, issued);
        issued++;
      end
      if (pv && !pr) begin
        chk("hold_valid", bus.out_valid, 1);
        chk("hold_data", bus.out_data, pd);
        chk("hold_last", bus.out_last, pl);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (first_cyc < 0) first_cyc = c;
        chk("out_last", bus.out_last, popped == N - 1);
        if (bus.out_last) last_cyc = c;
        got.push_back(bus.out_data);
        popped++;
      end
      chk("occupancy", (issued - popped) <= 2, 1);
      chk("busy", busy, !done);
      if (mode == 2 && c == 22) begin
        chk("stall_reads", issued <= 2, 1);
        chk("stall_data", bus.out_data, 0);
        chk("stall_valid", bus.out_valid, 1);
      end
      if (done) begin
        done_cnt++;
        done_cyc = c;
        seen = 1;
      end
      pv = bus.out_valid; pr = bus.out_ready;
      pd = bus.out_data;  pl = bus.out_last;
      @(posedge clk2); #1;
    end
    chk("done_seen", seen, 1);
    @(negedge clk2);
    chk("done_single", done, 0);
    chk("idle_busy", busy, 0);
    @(posedge clk2); #1;
  endtask

  initial begin
    bit found;
    tbl[0] = '{1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 16'd0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 6'd0, 1'b0, 16'd0, 1'b1};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 6'd1, 1'b0, 16'd0, 1'b1};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 6'd2, 1'b1, 16'd0, 1'b1};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 6'd3, 1'b1, 16'd1, 1'b1};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 6'd3, 1'b1, 16'd1, 1'b1};
    tbl[6] = '{1'b0, 1'b1, 1'b1, 6'd3, 1'b1, 16'd1, 1'b1};
    tbl[7] = '{1'b0, 1'b1, 1'b1, 6'd4, 1'b1, 16'd2, 1'b1};
    tbl[8] = '{1'b0, 1'b1, 1'b1, 6'd5, 1'b1, 16'd3, 1'b1};

    fill_ramp();
    rst = 1'b1;
    start_read = 1'b0;
    relu_en = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk2);
    #1 rst = 1'b0;
    @(negedge clk2);
    chk("rst_rd_en", bus.rd_en, 0);
    chk("rst_rd_addr", bus.rd_addr, 0);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_data", bus.out_data, 0);
    chk("rst_last", bus.out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(posedge clk2); #1;

    for (int i = 0; i < 9; i++) begin
      start_read = tbl[i].start;
      bus.out_ready = tbl[i].ready;
      @(negedge clk2);
      chk($sformatf("tbl%0d_rd_en", i), bus.rd_en, tbl[i].rd_en);
      chk($sformatf("tbl%0d_addr", i), bus.rd_addr, tbl[i].addr);
      chk($sformatf("tbl%0d_valid", i), bus.out_valid, tbl[i].valid);
      chk($sformatf("tbl%0d_data", i), bus.out_data, tbl[i].data);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].busy);
      @(posedge clk2); #1;
    end
    start_read = 1'b0;
    bus.out_ready = 1'b1;
    found = 0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(negedge clk2);
      found = done;
      @(posedge clk2); #1;
    end
    chk("tbl_done", found, 1);

    drain(0, 1'b0, 1'b0);
    check_stream("ramp", 1'b0);
    chk("first_valid_cyc", first_cyc, 3);
    chk("last_cyc", last_cyc, 51);
    chk("done_cyc", done_cyc, 52);

    fill_alt();
    drain(0, 1'b1, 1'b0);
    check_stream("alt_relu", 1'b1);
    drain(0, 1'b0, 1'b0);
    check_stream("alt_norelu", 1'b0);

    fill_ramp();
    drain(1, 1'b0, 1'b0);
    check_stream("rand_ready", 1'b0);
    drain(1, 1'b1, 1'b0);
    check_stream("rand_ready2", 1'b0);

    drain(2, 1'b0, 1'b0);
    check_stream("stall", 1'b0);
    chk("stall_first", first_cyc, 23);

    drain(0, 1'b0, 1'b1);
    check_stream("mid_start", 1'b0);

    start_read = 1'b1;
    relu_en = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk2); #1;
    start_read = 1'b0;
    found = 0;
    for (int c = 1; c < 100 && !found; c++) begin
      @(negedge clk2);
      found = bus.out_valid && (bus.out_data == 16'd20);
      if (!found) begin
        @(posedge clk2); #1;
      end
    end
    chk("rst_word20", found, 1);
    chk("rst_inflight", bus.rd_en, 1);
    rst = 1'b1;
    @(posedge clk2); #1;
    rst = 1'b0;
    chk("mid_rst_rd_en", bus.rd_en, 0);
    chk("mid_rst_rd_addr", bus.rd_addr, 0);
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_data", bus.out_data, 0);
    chk("mid_rst_last", bus.out_last, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    @(posedge clk2); #1;
    chk("discard_valid", bus.out_valid, 0);
    drain(0, 1'b0, 1'b0);
    check_stream("after_rst", 1'b0);
    chk("after_rst_first", first_cyc, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
